noc_port_arbiter: RTL

//  Per-output-port arbiter for the mesh router. Replaces the fixed-map port select with
//  an N_IN-way round-robin arbiter that locks the output to one input for a whole

---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_port_arbiter_if.sv | 29 ++
 rtl/noc_port_arbiter_rr_pick.sv | 33 +++
 rtl/noc_port_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types and constants: arbiter FSM states and port numbering.
package noc_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam int unsigned N_PORTS    = 4;
  localparam int unsigned PORT_X     = 0;
  localparam int unsigned PORT_Y     = 1;
  localparam int unsigned PORT_LOCAL = 2;

endpackage

// File: rtl/noc_port_arbiter_if.sv
// Request/grant bundle between routing logic (master) and one output-port arbiter (slave).
interface noc_port_arbiter_if import noc_pkg::*; #(
  parameter int unsigned N_IN = N_PORTS
) ();

  localparam int unsigned IDX_W = $clog2(N_IN);

  logic [N_IN-1:0]  req_i;
  logic [N_IN-1:0]  head_i;
  logic [N_IN-1:0]  tail_i;
  logic [N_IN-1:0]  fail_i;
  logic             out_ready_i;
  logic [N_IN-1:0]  grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             grant_valid_o;
  logic             xfer_o;
  logic             abort_o;

  modport master (
    output req_i, head_i, tail_i, fail_i, out_ready_i,
    input  grant_o, grant_idx_o, grant_valid_o, xfer_o, abort_o
  );

  modport slave (
    input  req_i, head_i, tail_i, fail_i, out_ready_i,
    output grant_o, grant_idx_o, grant_valid_o, xfer_o, abort_o
  );

endinterface

// File: rtl/noc_port_arbiter_rr_pick.sv
// rr_pick: combinational selector returning the first set request at or after ptr (wrapping).
module rr_pick #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned IDX_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned pos;
    logic [IDX_W-1:0] pos_idx;
    grant   = '0;
    idx     = '0;
    any     = |req;
    pos     = 0;
    pos_idx = '0;
    // Scan farthest offset first so the nearest candidate overwrites the rest.
    for (int unsigned k = N_IN; k > 0; k--) begin
      pos     = (32'(ptr) + k - 1) % N_IN;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        grant          = '0;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin output-port arbiter holding the grant for a whole wormhole packet.
// Optional ARB_TIMEOUT_EN releases a grant stalled for TIMEOUT cycles.
module noc_port_arbiter import noc_pkg::*; #(
  parameter int unsigned N_IN    = N_PORTS,
  parameter int unsigned IDX_W   = $clog2(N_IN),
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  noc_port_arbiter_if.slave bus
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gidx, gidx_nxt;
  logic [N_IN-1:0]  grant, grant_nxt;
  logic             abort, abort_nxt;

  logic [N_IN-1:0]  eligible;
  logic [N_IN-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             locked;
  logic             g_fail;
  logic             xfer;
  logic             timeout_hit;
  logic [IDX_W-1:0] ptr_after_g;

  assign eligible    = bus.req_i & bus.head_i & ~bus.fail_i;
  assign locked      = (state == ARB_LOCKED);
  assign g_fail      = bus.fail_i[gidx];
  // A failing granted input never transfers, even with its tail present.
  assign xfer        = locked & bus.req_i[gidx] & bus.out_ready_i & ~g_fail;
  assign ptr_after_g = (gidx == IDX_W'(N_IN - 1)) ? '0 : gidx + 1'b1;

  rr_pick #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;

  assign timeout_hit = locked & ~xfer & (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    stall_cnt_nxt = '0;
    if (locked && !xfer && state_nxt == ARB_LOCKED) stall_cnt_nxt = stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else     stall_cnt <= stall_cnt_nxt;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant;
    abort_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_LOCKED;
          gidx_nxt  = pick_idx;
          grant_nxt = pick_oh;
        end
      end
      ARB_LOCKED: begin
        if (g_fail || timeout_hit || (xfer && bus.tail_i[gidx])) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = ptr_after_g;
          gidx_nxt  = '0;
          grant_nxt = '0;
          abort_nxt = g_fail | timeout_hit;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      grant <= grant_nxt;
      abort <= abort_nxt;
    end
  end

  assign bus.grant_o       = grant;
  assign bus.grant_idx_o   = gidx;
  assign bus.grant_valid_o = locked;
  assign bus.xfer_o        = xfer;
  assign bus.abort_o       = abort;

endmodule
